fp_divider: RTL and testbench

- Iterative IEEE-754 single-precision divider; computes Data1 / Data2.
- Companion to the combinational FP multiplier: the inverse operation, for the same FPU datapath.
- Uses the same operand and valid conventions as the multiplier: 32-bit operands, In_Data_Valid strobe, result-valid output.
- Sequential restoring mantissa division, one quotient bit per clock. Results are truncated, not rounded.

---
 rtl/fp_divider.sv | 80 ++++++++
 tb/tb_fp_divider.sv | 105 ++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// fp_divider: iterative FP32 divider, Data1/Data2, one restoring quotient bit per clock, truncated result
// Ports: clk, rst (sync, active-high); Data1/Data2 FP32 operands with In_Data_Valid strobe (taken only when idle);
//        Data_Out quotient (held), div_Data_Out_Valid one-cycle pulse, div_Exception (div-by-zero/overflow/underflow), busy.
module fp_divider #(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  input  logic        In_Data_Valid,
  output logic [31:0] Data_Out,
  output logic        div_Data_Out_Valid,
  output logic        div_Exception,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
  state_t state, state_nxt;
  logic              sign, spec_inf, spec_zero, accept, special, ge;
  logic [7:0]        e1, e2;
  logic [23:0]       m2;
  logic [25:0]       r;
  logic [QBITS-1:0]  q;
  logic [4:0]        cnt;
  logic signed [9:0] e_raw, e_n;
  logic [22:0]       mant;
  assign accept  = state == IDLE && In_Data_Valid;
  assign special = Data2[30:23] == 8'd0 || Data1[30:23] == 8'd0;
  assign ge      = r >= {2'b00, m2};
  assign e_raw   = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
  // quotient lies in [0.5,2): without a leading one in the top bit, shift left and drop the exponent
  assign e_n     = q[QBITS-1] ? e_raw : e_raw - 10'sd1;
  assign mant    = q[QBITS-1] ? q[QBITS-2:1] : q[QBITS-3:0];
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // special cases skip DIVIDE but still pass through NORM so Data_Out is loaded one edge after accept
  always_comb
    state_nxt = state == IDLE   ? (accept ? (special ? NORM : DIVIDE) : IDLE) :
                state == DIVIDE ? (cnt == 5'(QBITS - 1) ? NORM : DIVIDE) :
                state == NORM   ? DONE : IDLE;
  always_comb begin
    busy               = state != IDLE;
    div_Data_Out_Valid = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      Data_Out      <= '0;
      div_Exception <= 1'b0;
      sign          <= 1'b0;
      spec_inf      <= 1'b0;
      spec_zero     <= 1'b0;
      e1            <= '0;
      e2            <= '0;
      m2            <= '0;
      r             <= '0;
      q             <= '0;
      cnt           <= '0;
    end else if (accept) begin
      sign      <= Data1[31] ^ Data2[31];
      e1        <= Data1[30:23];
      e2        <= Data2[30:23];
      m2        <= {1'b1, Data2[22:0]};
      spec_inf  <= Data2[30:23] == 8'd0;
      spec_zero <= Data2[30:23] != 8'd0 && Data1[30:23] == 8'd0;
      r         <= {2'b00, 1'b1, Data1[22:0]};
      q         <= '0;
      cnt       <= '0;
    end else if (state == DIVIDE) begin
      r   <= ge ? (r - {2'b00, m2}) << 1 : r << 1;
      q   <= {q[QBITS-2:0], ge};
      cnt <= cnt + 5'd1;
    end else if (state == NORM) begin
      Data_Out      <= spec_inf  ? {sign, 8'hFF, 23'd0} :
                       spec_zero ? {sign, 31'd0} :
                       e_n >= 10'sd255 ? {sign, 8'hFF, 23'd0} :
                       e_n <= 10'sd0   ? {sign, 31'd0} : {sign, e_n[7:0], mant};
      div_Exception <= spec_inf || (!spec_zero && (e_n >= 10'sd255 || e_n <= 10'sd0));
    end
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed vectors with hand-computed FP32 quotients for fp_divider
module tb_fp_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Data1 = '0;
  logic [31:0] Data2 = '0;
  logic        In_Data_Valid = 1'b0;
  logic [31:0] Data_Out;
  logic        div_Data_Out_Valid, div_Exception, busy;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat, pulses;
  logic        busy_dropped;
  fp_divider dut (
    .clk(clk), .rst(rst), .Data1(Data1), .Data2(Data2), .In_Data_Valid(In_Data_Valid),
    .Data_Out(Data_Out), .div_Data_Out_Valid(div_Data_Out_Valid),
    .div_Exception(div_Exception), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Data1 = a;
    Data2 = b;
    In_Data_Valid = 1'b1;
    @(posedge clk);
    #1 In_Data_Valid = 1'b0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    busy_dropped = 1'b0;
    while (!div_Data_Out_Valid && n < 100) begin
      @(posedge clk);
      #1 n++;
      if (!busy) busy_dropped = 1'b1;
    end
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input logic exc, input int exp_lat);
    start(a, b);
    wait_valid(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_out"}, Data_Out, exp);
    check({tag, "_exc"}, 32'(div_Exception), 32'(exc));
    @(posedge clk);
    #1 check({tag, "_pulse_end"}, 32'(div_Data_Out_Valid), 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", Data_Out, 32'h0);
    check("rst_valid", 32'(div_Data_Out_Valid), 32'd0);
    check("rst_exc", 32'(div_Exception), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    run("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);
    check("busy_throughout", 32'(busy_dropped), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    run("one_third", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26);
    run("neg_1p5_by_half", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 26);
    run("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1);
    run("zero_num", 32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1);
    run("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 26);
    run("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b1, 26);
    run("neg_div_zero", 32'hC0000000, 32'h80000000, 32'h7F800000, 1'b1, 1);
    // second strobe while busy must be dropped
    start(32'h40C00000, 32'h40000000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    Data1 = 32'h3F800000;
    Data2 = 32'h40400000;
    In_Data_Valid = 1'b1;
    @(posedge clk);
    #1 In_Data_Valid = 1'b0;
    wait_valid(lat);
    check("ignore_lat", 32'(lat), 32'd20);
    check("ignore_out", Data_Out, 32'h40400000);
    repeat (2) @(posedge clk);
    #1 check("ignore_no_second", 32'(busy), 32'd0);
    // reset during DIVIDE aborts without a pulse
    start(32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", Data_Out, 32'h0);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (div_Data_Out_Valid) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    run("after_abort", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
